// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_access_ctrl
//  Purpose  : MEM-stage sequencer that turns a single-cycle load/store
//             (MemRead/MemWrite) into a req/gnt + rvalid handshake with a
//             variable-latency data memory, stalling the pipeline until the
//             access completes and flagging misaligned/illegal accesses and
//             timeouts.
//
//  Ports
//    clk            in   rising-edge clock
//    reset          in   synchronous active-low reset
//    mem_read_i     in   MemRead of the instruction in MEM
//    mem_write_i    in   MemWrite of the instruction in MEM
//    funct3_i       in   access size (000 b, 001 h, 010 w, 100 bu, 101 hu)
//    addr_i         in   byte address from the ALU
//    wdata_i        in   store data
//    dmem_req_o     out  request valid to memory
//    dmem_we_o      out  1 = write
//    dmem_addr_o    out  registered address
//    dmem_wdata_o   out  registered store data
//    dmem_funct3_o  out  registered access size
//    dmem_gnt_i     in   memory accepts the request this cycle
//    dmem_rvalid_i  in   response valid (read data or write ack)
//    dmem_rdata_i   in   read data (already extended by memory)
//    stall_o        out  freeze PC, IF/ID, ID/EX, EX/MEM
//    rdata_o        out  load result, held until the next load completes
//    done_o         out  one-cycle pulse, access finished
//    err_o          out  one-cycle pulse, misaligned / illegal / timeout
//
//  Revision : 1.0  initial release
// ============================================================================
module dmem_access_ctrl #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic [2:0]        funct3_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [DATA_W-1:0] dmem_wdata_o,
    output logic [2:0]        dmem_funct3_o,
    input  logic              dmem_gnt_i,
    input  logic              dmem_rvalid_i,
    input  logic [DATA_W-1:0] dmem_rdata_i,
    output logic              stall_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              done_o,
    output logic              err_o
);

    // TIMEOUT is limited to 1..255, so an 8-bit counter always suffices.
    localparam logic [7:0] c_timeout = 8'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t              state_q,  state_d;
    logic [7:0]          cnt_q,    cnt_d;
    logic [ADDR_W-1:0]   addr_q,   addr_d;
    logic [DATA_W-1:0]   wdata_q,  wdata_d;
    logic [2:0]          funct3_q, funct3_d;
    logic                we_q,     we_d;
    logic [DATA_W-1:0]   rdata_q,  rdata_d;

    logic                access_req;
    logic                access_legal;
    logic                timed_out;

    assign access_req = mem_read_i | mem_write_i;
    assign timed_out  = (cnt_q == c_timeout);

    // ------------------------------------------------------------------
    // Legality check: size encoding and natural alignment. A simultaneous
    // read and write has no meaning and is rejected as well.
    // ------------------------------------------------------------------
    always_comb begin
        access_legal = 1'b0;
        case (funct3_i)
            3'b000, 3'b100: access_legal = 1'b1;
            3'b001, 3'b101: access_legal = ~addr_i[0];
            3'b010:         access_legal = (addr_i[1:0] == 2'b00);
            default:        access_legal = 1'b0;
        endcase
        if (mem_read_i && mem_write_i) begin
            access_legal = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic and stall generation
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        funct3_d = funct3_q;
        we_d     = we_q;
        rdata_d  = rdata_q;
        stall_o  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Stall must rise in the same cycle the access is seen so
                // EX/MEM holds the instruction while it is serviced.
                if (access_req) begin
                    stall_o = 1'b1;
                    if (access_legal) begin
                        addr_d   = addr_i;
                        wdata_d  = wdata_i;
                        funct3_d = funct3_i;
                        we_d     = mem_write_i;
                        cnt_d    = 8'd0;
                        state_d  = S_REQ;
                    end else begin
                        state_d  = S_ERR;
                    end
                end
            end

            S_REQ: begin
                stall_o = 1'b1;
                cnt_d   = cnt_q + 8'd1;
                // A response coincident with the grant is accepted directly;
                // any response arriving before the grant is not ours.
                if (dmem_gnt_i && dmem_rvalid_i) begin
                    if (!we_q) begin
                        rdata_d = dmem_rdata_i;
                    end
                    state_d = S_DONE;
                end else if (timed_out) begin
                    state_d = S_ERR;
                end else if (dmem_gnt_i) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                stall_o = 1'b1;
                cnt_d   = cnt_q + 8'd1;
                if (dmem_rvalid_i) begin
                    if (!we_q) begin
                        rdata_d = dmem_rdata_i;
                    end
                    state_d = S_DONE;
                end else if (timed_out) begin
                    state_d = S_ERR;
                end
            end

            // The pipeline advances during DONE/ERR, so the mem_* inputs
            // still describe the finished instruction and must be ignored.
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 8'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
            funct3_q <= 3'b000;
            we_q     <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            funct3_q <= funct3_d;
            we_q     <= we_d;
            rdata_q  <= rdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign dmem_req_o    = (state_q == S_REQ);
    assign dmem_we_o     = we_q;
    assign dmem_addr_o   = addr_q;
    assign dmem_wdata_o  = wdata_q;
    assign dmem_funct3_o = funct3_q;
    assign rdata_o       = rdata_q;
    assign done_o        = (state_q == S_DONE);
    assign err_o         = (state_q == S_ERR);

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_access_ctrl
//  Purpose  : Directed self-checking bench for dmem_access_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dmem_access_ctrl;

    localparam int ADDR_W  = 9;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              reset;
    logic              mem_read_i;
    logic              mem_write_i;
    logic [2:0]        funct3_i;
    logic [ADDR_W-1:0] addr_i;
    logic [DATA_W-1:0] wdata_i;
    logic              dmem_req_o;
    logic              dmem_we_o;
    logic [ADDR_W-1:0] dmem_addr_o;
    logic [DATA_W-1:0] dmem_wdata_o;
    logic [2:0]        dmem_funct3_o;
    logic              dmem_gnt_i;
    logic              dmem_rvalid_i;
    logic [DATA_W-1:0] dmem_rdata_i;
    logic              stall_o;
    logic [DATA_W-1:0] rdata_o;
    logic              done_o;
    logic              err_o;

    int tests_run = 0;
    int fails     = 0;

    // Running counts of cycles each output was high, sampled mid-cycle.
    int req_cycles   = 0;
    int done_cycles  = 0;
    int stall_cycles = 0;

    dmem_access_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_read_i   (mem_read_i),
        .mem_write_i  (mem_write_i),
        .funct3_i     (funct3_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_funct3_o(dmem_funct3_o),
        .dmem_gnt_i   (dmem_gnt_i),
        .dmem_rvalid_i(dmem_rvalid_i),
        .dmem_rdata_i (dmem_rdata_i),
        .stall_o      (stall_o),
        .rdata_o      (rdata_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dmem_req_o === 1'b1) req_cycles++;
        if (done_o === 1'b1)     done_cycles++;
        if (stall_o === 1'b1)    stall_cycles++;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_idle();
        mem_read_i    = 1'b0;
        mem_write_i   = 1'b0;
        funct3_i      = 3'b000;
        addr_i        = '0;
        wdata_i       = '0;
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = '0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b0;
        drive_idle();
        tick();
        tick();
        #1;
        tests_run++;
        if ({dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_funct3_o,
             rdata_o, done_o, err_o, stall_o} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got req=%b we=%b addr=%h wdata=%h f3=%b rdata=%h done=%b err=%b stall=%b, required all 0",
                     dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_funct3_o,
                     rdata_o, done_o, err_o, stall_o);
        end
        reset = 1'b1;
        tick();
        #1;
        tests_run++;
        if ({dmem_req_o, done_o, err_o, stall_o} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_release_idle: got req/done/err/stall=%b, required 0000",
                     {dmem_req_o, done_o, err_o, stall_o});
        end
    endtask

    // ------------------------------------------------------------------
    // lw 0x010, gnt in first REQ cycle, rvalid two cycles later.
    task automatic test_load();
        int s0;
        s0 = stall_cycles;
        mem_read_i = 1'b1; funct3_i = 3'b010; addr_i = 9'h010;
        #1;
        tests_run++;
        if ({stall_o, dmem_req_o} !== 2'b10) begin
            fails++;
            $display("FAIL load_c0: got stall/req=%b, required 10", {stall_o, dmem_req_o});
        end
        tick(); dmem_gnt_i = 1'b1; #1;
        tests_run++;
        if ({dmem_req_o, dmem_we_o, dmem_addr_o, dmem_funct3_o} !== {1'b1, 1'b0, 9'h010, 3'b010}) begin
            fails++;
            $display("FAIL load_req: got req=%b we=%b addr=%h f3=%b, required 1 0 010 010",
                     dmem_req_o, dmem_we_o, dmem_addr_o, dmem_funct3_o);
        end
        tick(); dmem_gnt_i = 1'b0; #1;
        tests_run++;
        if ({dmem_req_o, stall_o} !== 2'b01) begin
            fails++;
            $display("FAIL load_req_drop: got req/stall=%b, required 01", {dmem_req_o, stall_o});
        end
        tick(); dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hDEADBEEF; #1;
        tests_run++;
        if ({done_o, stall_o} !== 2'b01) begin
            fails++;
            $display("FAIL load_wait: got done/stall=%b, required 01", {done_o, stall_o});
        end
        tick(); dmem_rvalid_i = 1'b0; dmem_rdata_i = '0; #1;
        tests_run++;
        if ({done_o, stall_o, err_o} !== 3'b100) begin
            fails++;
            $display("FAIL load_done: got done/stall/err=%b, required 100", {done_o, stall_o, err_o});
        end
        tests_run++;
        if (rdata_o !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL load_rdata: got %h, required deadbeef", rdata_o);
        end
        tick(); drive_idle(); #1;
        tests_run++;
        if ({done_o, dmem_req_o, stall_o} !== 3'b000 || (stall_cycles - s0) != 4) begin
            fails++;
            $display("FAIL load_stall_count: got stall cycles=%0d done/req/stall=%b, required 4 and 000",
                     stall_cycles - s0, {done_o, dmem_req_o, stall_o});
        end
    endtask

    // ------------------------------------------------------------------
    // sw 0x024, gnt delayed 3 cycles; inputs wiggle to prove registering.
    task automatic test_store();
        int sr;
        sr = req_cycles;
        mem_write_i = 1'b1; funct3_i = 3'b010; addr_i = 9'h024; wdata_i = 32'h12345678;
        #1;
        tests_run++;
        if (stall_o !== 1'b1) begin
            fails++;
            $display("FAIL store_c0_stall: got %b, required 1", stall_o);
        end
        for (int i = 0; i < 3; i++) begin
            tick(); addr_i = 9'h1FC; wdata_i = 32'hFFFF0000; #1;
            tests_run++;
            if ({dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_funct3_o} !==
                {1'b1, 1'b1, 9'h024, 32'h12345678, 3'b010}) begin
                fails++;
                $display("FAIL store_hold[%0d]: got req=%b we=%b addr=%h wdata=%h f3=%b, required 1 1 024 12345678 010",
                         i, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_funct3_o);
            end
        end
        tick(); dmem_gnt_i = 1'b1; #1;
        tests_run++;
        if (dmem_req_o !== 1'b1) begin
            fails++;
            $display("FAIL store_gnt_cycle: got req=%b, required 1", dmem_req_o);
        end
        tick(); dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hBAD0BAD0; #1;
        tests_run++;
        if ({dmem_req_o, stall_o} !== 2'b01) begin
            fails++;
            $display("FAIL store_wait: got req/stall=%b, required 01", {dmem_req_o, stall_o});
        end
        tick(); dmem_rvalid_i = 1'b0; #1;
        tests_run++;
        if ({done_o, stall_o} !== 2'b10 || rdata_o !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL store_done: got done/stall=%b rdata=%h, required 10 deadbeef",
                     {done_o, stall_o}, rdata_o);
        end
        tick(); drive_idle(); #1;
        tests_run++;
        if ((req_cycles - sr) != 4 || dmem_req_o !== 1'b0) begin
            fails++;
            $display("FAIL store_req_cycles: got %0d req=%b, required 4 and 0", req_cycles - sr, dmem_req_o);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_illegal();
        logic [1:0] rw [6];
        logic [2:0] f3 [6];
        logic [8:0] ad [6];
        int sr;
        rw = '{2'b10, 2'b11, 2'b10, 2'b01, 2'b10, 2'b10};
        f3 = '{3'b010, 3'b010, 3'b001, 3'b001, 3'b111, 3'b010};
        ad = '{9'h013, 9'h010, 9'h011, 9'h005, 9'h000, 9'h012};
        for (int v = 0; v < 6; v++) begin
            sr = req_cycles;
            mem_read_i = rw[v][1]; mem_write_i = rw[v][0]; funct3_i = f3[v]; addr_i = ad[v];
            wdata_i = 32'hA5A5A5A5;
            #1;
            tests_run++;
            if ({stall_o, dmem_req_o} !== 2'b10) begin
                fails++;
                $display("FAIL illegal_c0[%0d]: got stall/req=%b, required 10", v, {stall_o, dmem_req_o});
            end
            tick(); #1;
            tests_run++;
            if ({err_o, done_o, stall_o, dmem_req_o} !== 4'b1000) begin
                fails++;
                $display("FAIL illegal_err[%0d]: got err/done/stall/req=%b, required 1000",
                         v, {err_o, done_o, stall_o, dmem_req_o});
            end
            tick(); drive_idle(); #1;
            tests_run++;
            if (err_o !== 1'b0 || req_cycles != sr) begin
                fails++;
                $display("FAIL illegal_after[%0d]: got err=%b req cycles=%0d, required 0 and 0",
                         v, err_o, req_cycles - sr);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_timeout();
        int bad;
        mem_read_i = 1'b1; funct3_i = 3'b010; addr_i = 9'h020;
        #1;
        tick(); dmem_gnt_i = 1'b1; #1;       // REQ entry, index 0
        tests_run++;
        if (dmem_req_o !== 1'b1) begin
            fails++;
            $display("FAIL timeout_req: got req=%b, required 1", dmem_req_o);
        end
        bad = 0;
        for (int i = 1; i < 16; i++) begin
            tick(); dmem_gnt_i = 1'b0; #1;
            if (err_o !== 1'b0 || stall_o !== 1'b1 || dmem_req_o !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            fails++;
            $display("FAIL timeout_waiting: got %0d bad cycles, required 0", bad);
        end
        tick(); #1;                          // index 16
        tests_run++;
        if ({err_o, stall_o, dmem_req_o, done_o} !== 4'b1000 || rdata_o !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL timeout_err: got err/stall/req/done=%b rdata=%h, required 1000 deadbeef",
                     {err_o, stall_o, dmem_req_o, done_o}, rdata_o);
        end
        tick(); drive_idle(); dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hCAFEF00D; #1;
        tick(); dmem_rvalid_i = 1'b0; #1;
        tests_run++;
        if (rdata_o !== 32'hDEADBEEF || {done_o, err_o, dmem_req_o, stall_o} !== 4'b0000) begin
            fails++;
            $display("FAIL late_rvalid_ignored: got rdata=%h done/err/req/stall=%b, required deadbeef 0000",
                     rdata_o, {done_o, err_o, dmem_req_o, stall_o});
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid();
        int s0;
        mem_read_i = 1'b1; funct3_i = 3'b010; addr_i = 9'h030;
        #1;
        tick(); dmem_gnt_i = 1'b1; #1;
        tick(); dmem_gnt_i = 1'b0; reset = 1'b0; #1;
        tests_run++;
        if (stall_o !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_wait: got stall=%b, required 1", stall_o);
        end
        tick(); reset = 1'b1; drive_idle(); dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h00000055; #1;
        tests_run++;
        if ({dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_funct3_o,
             rdata_o, done_o, err_o, stall_o} !== '0) begin
            fails++;
            $display("FAIL reset_mid_outputs: got req=%b addr=%h f3=%b rdata=%h done=%b err=%b stall=%b, required all 0",
                     dmem_req_o, dmem_addr_o, dmem_funct3_o, rdata_o, done_o, err_o, stall_o);
        end
        tick(); dmem_rvalid_i = 1'b0; dmem_rdata_i = '0; #1;
        tests_run++;
        if ({done_o, err_o, dmem_req_o} !== 3'b000 || rdata_o !== 32'h0) begin
            fails++;
            $display("FAIL reset_mid_rvalid_ignored: got done/err/req=%b rdata=%h, required 000 0",
                     {done_o, err_o, dmem_req_o}, rdata_o);
        end
        // Fresh lw with zero-wait memory: stall in cycles 0-2, DONE in cycle 3.
        s0 = stall_cycles;
        mem_read_i = 1'b1; funct3_i = 3'b010; addr_i = 9'h034;
        #1;
        tick(); dmem_gnt_i = 1'b1; #1;
        tests_run++;
        if ({dmem_req_o, dmem_addr_o} !== {1'b1, 9'h034}) begin
            fails++;
            $display("FAIL after_reset_req: got req=%b addr=%h, required 1 034", dmem_req_o, dmem_addr_o);
        end
        tick(); dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hA5A50001; #1;
        tick(); dmem_rvalid_i = 1'b0; #1;
        tests_run++;
        if (done_o !== 1'b1 || rdata_o !== 32'hA5A50001) begin
            fails++;
            $display("FAIL after_reset_done: got done=%b rdata=%h, required 1 a5a50001", done_o, rdata_o);
        end
        tick(); drive_idle(); #1;
        tests_run++;
        if ((stall_cycles - s0) != 3) begin
            fails++;
            $display("FAIL after_reset_latency: got %0d stall cycles, required 3", stall_cycles - s0);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_back_to_back();
        int sr, sd;
        sr = req_cycles;
        sd = done_cycles;
        mem_read_i = 1'b1; funct3_i = 3'b010; addr_i = 9'h040;
        #1;
        tick(); dmem_gnt_i = 1'b1; #1;
        tests_run++;
        if ({dmem_req_o, dmem_we_o, dmem_addr_o} !== {1'b1, 1'b0, 9'h040}) begin
            fails++;
            $display("FAIL b2b_lw_req: got req=%b we=%b addr=%h, required 1 0 040",
                     dmem_req_o, dmem_we_o, dmem_addr_o);
        end
        tick(); dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h11223344; #1;
        tick(); dmem_rvalid_i = 1'b0; #1;
        tests_run++;
        if ({done_o, stall_o} !== 2'b10) begin
            fails++;
            $display("FAIL b2b_lw_done: got done/stall=%b, required 10", {done_o, stall_o});
        end
        tick();
        mem_read_i = 1'b0; mem_write_i = 1'b1; addr_i = 9'h044; wdata_i = 32'h0BADF00D;
        #1;
        tests_run++;
        if ({done_o, dmem_req_o, stall_o} !== 3'b001) begin
            fails++;
            $display("FAIL b2b_sw_idle: got done/req/stall=%b, required 001", {done_o, dmem_req_o, stall_o});
        end
        tick(); dmem_gnt_i = 1'b1; #1;
        tests_run++;
        if ({dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o} !== {1'b1, 1'b1, 9'h044, 32'h0BADF00D}) begin
            fails++;
            $display("FAIL b2b_sw_req: got req=%b we=%b addr=%h wdata=%h, required 1 1 044 0badf00d",
                     dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o);
        end
        tick(); dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hFFFFFFFF; #1;
        tick(); dmem_rvalid_i = 1'b0; #1;
        tests_run++;
        if (done_o !== 1'b1 || rdata_o !== 32'h11223344) begin
            fails++;
            $display("FAIL b2b_sw_done: got done=%b rdata=%h, required 1 11223344", done_o, rdata_o);
        end
        tick(); drive_idle(); #1;
        tests_run++;
        if ((req_cycles - sr) != 2 || (done_cycles - sd) != 2) begin
            fails++;
            $display("FAIL b2b_counts: got req cycles=%0d done pulses=%0d, required 2 and 2",
                     req_cycles - sr, done_cycles - sd);
        end
    endtask

    initial begin
        reset = 1'b0;
        drive_idle();
        test_reset();
        test_load();
        test_store();
        test_illegal();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
`default_nettype wire
